// File: rtl/ahb3lite_interconnect_switch_ctrl.sv
// ============================================================================
// ahb3lite_interconnect_switch_ctrl
// ----------------------------------------------------------------------------
// Per-slave-port transfer tracker for the multi-layer AHB switch. It watches
// the granted master's control signals as seen by the slave and produces
// can_switch, the "arbiter may re-grant at this HREADY edge" qualifier.
// Fixed-length bursts and locked sequences are never split. Undefined-length
// INCR bursts are bounded by a hold quantum (MAX_HOLD accepted beats) when
// another master of equal or higher priority is waiting.
//
// Ports:
//   HRESETn      in   async active-low reset
//   HCLK         in   clock
//   HSEL         in   granted master's select toward this slave
//   HTRANS[1:0]  in   granted master's HTRANS
//   HBURST[2:0]  in   granted master's HBURST
//   HMASTLOCK    in   granted master's lock
//   HREADY       in   slave-side HREADY
//   req_other    in   competing request at priority >= current owner
//   can_switch   out  combinational re-grant permission
//   burst_active out  registered, tracker not IDLE
//   lock_active  out  registered, tracker LOCKED
//   beats_left   out  registered, remaining SEQ beats of a fixed burst
//   preempt      out  registered 1-cycle pulse, INCR burst force-terminated
// ============================================================================
module ahb3lite_interconnect_switch_ctrl #(
   parameter int MAX_HOLD  = 16,
   parameter int HOLD_BITS = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
   input  logic       HRESETn,
   input  logic       HCLK,
   input  logic       HSEL,
   input  logic [1:0] HTRANS,
   input  logic [2:0] HBURST,
   input  logic       HMASTLOCK,
   input  logic       HREADY,
   input  logic       req_other,
   output logic       can_switch,
   output logic       burst_active,
   output logic       lock_active,
   output logic [4:0] beats_left,
   output logic       preempt
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BURST  = 2'd1,
      S_UNDEF  = 2'd2,
      S_LOCKED = 2'd3
   } state_t;

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   localparam logic [HOLD_BITS-1:0] HOLD_MAX = HOLD_BITS'(MAX_HOLD);
   localparam logic [HOLD_BITS-1:0] HOLD_THR = (MAX_HOLD > 0) ? HOLD_BITS'(MAX_HOLD - 1) : '0;

   state_t                r_state;
   logic [4:0]            r_beats_left;
   logic [HOLD_BITS-1:0]  r_hold_cnt;
   logic                  r_preempt;
   logic                  r_burst_active;
   logic                  r_lock_active;

   state_t                w_state_next;
   logic [4:0]            w_beats_next;
   logic [HOLD_BITS-1:0]  w_hold_next;
   logic                  w_preempt_next;

   logic                  w_acc;
   logic                  w_nsq;
   logic                  w_sq;
   logic                  w_term;
   logic                  w_single;
   logic                  w_lock_acc;
   logic                  w_preempt_hit;
   logic                  w_can;
   state_t                w_start_state;
   logic [4:0]            w_start_beats;
   logic [HOLD_BITS-1:0]  w_start_hold;

   // Transfer qualifiers
   assign w_acc      = HREADY & HSEL & HTRANS[1];
   assign w_nsq      = w_acc & (HTRANS == TR_NONSEQ);
   assign w_sq       = w_acc & (HTRANS == TR_SEQ);
   assign w_term     = ~HSEL | (HTRANS == TR_IDLE);
   assign w_single   = (HBURST == 3'd0);
   assign w_lock_acc = w_acc & HMASTLOCK;

   // Hold quantum expired on this accepted SEQ beat and someone is waiting
   assign w_preempt_hit = (MAX_HOLD != 0) && (r_hold_cnt >= HOLD_THR) && w_sq && req_other;

   // Where a NONSEQ (from any state) takes the tracker
   always_comb begin
      w_start_state = S_IDLE;
      w_start_beats = 5'd0;
      w_start_hold  = '0;
      case (HBURST)
         3'd1: begin
            w_start_state = S_UNDEF;
            w_start_hold  = HOLD_BITS'(1);
         end
         3'd2, 3'd3: begin
            w_start_state = S_BURST;
            w_start_beats = 5'd3;
         end
         3'd4, 3'd5: begin
            w_start_state = S_BURST;
            w_start_beats = 5'd7;
         end
         3'd6, 3'd7: begin
            w_start_state = S_BURST;
            w_start_beats = 5'd15;
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state        <= S_IDLE;
         r_beats_left   <= 5'd0;
         r_hold_cnt     <= '0;
         r_preempt      <= 1'b0;
         r_burst_active <= 1'b0;
         r_lock_active  <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_beats_left   <= w_beats_next;
         r_hold_cnt     <= w_hold_next;
         r_preempt      <= w_preempt_next;
         r_burst_active <= (w_state_next != S_IDLE);
         r_lock_active  <= (w_state_next == S_LOCKED);
      end
   end

   // Next-state logic; lock acceptance wins over everything else
   always_comb begin
      w_state_next   = r_state;
      w_beats_next   = r_beats_left;
      w_hold_next    = r_hold_cnt;
      w_preempt_next = 1'b0;
      if (w_lock_acc) begin
         w_state_next = S_LOCKED;
         w_beats_next = 5'd0;
         w_hold_next  = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_nsq) begin
                  w_state_next = w_start_state;
                  w_beats_next = w_start_beats;
                  w_hold_next  = w_start_hold;
               end
            end
            S_BURST: begin
               if (w_nsq) begin
                  w_state_next = w_start_state;
                  w_beats_next = w_start_beats;
                  w_hold_next  = w_start_hold;
               end else if (w_sq) begin
                  if (r_beats_left <= 5'd1) begin
                     w_state_next = S_IDLE;
                     w_beats_next = 5'd0;
                  end else begin
                     w_beats_next = r_beats_left - 5'd1;
                  end
               end else if (HREADY && w_term) begin
                  w_state_next = S_IDLE;
                  w_beats_next = 5'd0;
               end
            end
            S_UNDEF: begin
               if (w_nsq) begin
                  w_state_next = w_start_state;
                  w_beats_next = w_start_beats;
                  w_hold_next  = w_start_hold;
               end else if (w_preempt_hit) begin
                  w_state_next   = S_IDLE;
                  w_hold_next    = '0;
                  w_preempt_next = 1'b1;
               end else if (w_sq) begin
                  if (r_hold_cnt < HOLD_MAX) begin
                     w_hold_next = r_hold_cnt + HOLD_BITS'(1);
                  end
               end else if (HREADY && w_term) begin
                  w_state_next = S_IDLE;
                  w_hold_next  = '0;
               end
            end
            S_LOCKED: begin
               if (HREADY && !HMASTLOCK) begin
                  if (w_term) begin
                     w_state_next = S_IDLE;
                  end else if (w_nsq) begin
                     w_state_next = w_start_state;
                     w_beats_next = w_start_beats;
                     w_hold_next  = w_start_hold;
                  end
               end
            end
            default: begin
               w_state_next = S_IDLE;
               w_beats_next = 5'd0;
               w_hold_next  = '0;
            end
         endcase
      end
   end

   // Output logic: re-grant permission for the current HREADY edge.
   // An asserted HMASTLOCK always vetoes switching.
   always_comb begin
      w_can = 1'b0;
      case (r_state)
         S_IDLE:   w_can = ~(w_nsq & ~w_single);
         S_BURST:  w_can = HREADY & ((w_sq & (r_beats_left <= 5'd1)) | w_term | (w_nsq & w_single));
         S_UNDEF:  w_can = HREADY & (w_preempt_hit | w_term | (w_nsq & w_single));
         S_LOCKED: w_can = HREADY & (w_term | (w_nsq & w_single));
         default:  w_can = 1'b1;
      endcase
   end

   assign can_switch   = w_can & ~HMASTLOCK;
   assign burst_active = r_burst_active;
   assign lock_active  = r_lock_active;
   assign beats_left   = r_beats_left;
   assign preempt      = r_preempt;

endmodule
